// File: rtl/uio_cmd_master.sv
// UIO bus initiator: frames host requests into io_uio/io_strobe word sequences and
// captures the decoder's registered io_dout for status polls and DMA reads.
module uio_cmd_master #(
    parameter int STROBE_GAP = 1,
    parameter int FRAME_GAP  = 2
) (
    input  logic        clk_sys,
    input  logic        reset_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [7:0]  req_cmd,
    input  logic [15:0] req_arg,
    input  logic [7:0]  req_len,
    input  logic [15:0] wr_data,
    input  logic        wr_valid,
    output logic        wr_ready,
    output logic [15:0] rd_data,
    output logic        rd_valid,
    output logic [5:0]  status,
    output logic        status_valid,
    output logic        err,
    output logic        busy,
    output logic        io_uio,
    output logic        io_strobe,
    output logic [15:0] io_din,
    input  logic [15:0] io_dout
);
    typedef enum logic [3:0] {
        IDLE, SETUP, CMD, ARG, PAD, DATA, WAIT_WR, SAMPLE, GAP, END
    } state_t;

    localparam int             EW     = (FRAME_GAP > 1) ? $clog2(FRAME_GAP) : 1;
    localparam logic [3:0]     GAP_LD = 4'(STROBE_GAP - 1);
    localparam logic [EW-1:0]  END_LD = EW'(FRAME_GAP - 1);

    state_t        state, nxt;
    logic [7:0]    cmd;
    logic [15:0]   arg;
    logic [7:0]    cnt;
    logic [3:0]    gap_cnt;
    logic [EW-1:0] end_cnt;
    logic          is_dma, is_wr, launch;

    function automatic logic supported(input logic [7:0] c);
        case (c)
            8'h02, 8'h03, 8'h04, 8'h05, 8'h61, 8'h62, 8'h63: return 1'b1;
            default: return 1'b0;
        endcase
    endfunction

    assign is_dma = (cmd == 8'h61) || (cmd == 8'h62);
    assign is_wr  = (cmd == 8'h61);
    // Next word goes out once the gap has drained, or when a stalled write gets data.
    assign launch = ((state == GAP || state == SAMPLE) && gap_cnt == 4'd0) || (state == WAIT_WR);

    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            state        <= IDLE;
            nxt          <= IDLE;
            cmd          <= 8'h00;
            arg          <= 16'h0000;
            cnt          <= 8'h00;
            gap_cnt      <= 4'd0;
            end_cnt      <= '0;
            req_ready    <= 1'b1;
            wr_ready     <= 1'b0;
            rd_data      <= 16'h0000;
            rd_valid     <= 1'b0;
            status       <= 6'h00;
            status_valid <= 1'b0;
            err          <= 1'b0;
            busy         <= 1'b0;
            io_uio       <= 1'b0;
            io_strobe    <= 1'b0;
            io_din       <= 16'h0000;
        end else begin
            io_strobe    <= 1'b0;
            io_din       <= 16'h0000;
            wr_ready     <= 1'b0;
            rd_valid     <= 1'b0;
            status_valid <= 1'b0;
            err          <= 1'b0;

            case (state)
                IDLE: if (req_valid) begin
                    cmd       <= req_cmd;
                    arg       <= req_arg;
                    cnt       <= req_len;
                    req_ready <= 1'b0;
                    busy      <= 1'b1;
                    if (supported(req_cmd)) begin
                        state  <= SETUP;
                        io_uio <= 1'b1;
                    end else begin
                        err     <= 1'b1;
                        state   <= END;
                        end_cnt <= END_LD;
                    end
                end
                SETUP: begin
                    state     <= CMD;
                    io_strobe <= 1'b1;
                    io_din    <= {8'h00, cmd};
                    nxt       <= (cmd == 8'h63) ? END : ARG;
                end
                CMD, ARG, PAD, DATA: begin
                    gap_cnt <= GAP_LD;
                    // The first gap cycle doubles as the read-back sample point.
                    state   <= ((state == CMD && cmd == 8'h63) || (state == DATA && cmd == 8'h62))
                               ? SAMPLE : GAP;
                end
                SAMPLE: begin
                    if (cmd == 8'h63) begin
                        if (io_dout[15:12] == 4'hE) begin
                            status       <= io_dout[5:0];
                            status_valid <= 1'b1;
                        end else begin
                            err <= 1'b1;
                        end
                    end else begin
                        rd_data  <= io_dout;
                        rd_valid <= 1'b1;
                    end
                    if (gap_cnt != 4'd0) begin
                        gap_cnt <= gap_cnt - 4'd1;
                        state   <= GAP;
                    end
                end
                GAP: if (gap_cnt != 4'd0) gap_cnt <= gap_cnt - 4'd1;
                WAIT_WR: begin
                end
                END: begin
                    if (end_cnt == '0) begin
                        state     <= IDLE;
                        req_ready <= 1'b1;
                        busy      <= 1'b0;
                    end else begin
                        end_cnt <= end_cnt - 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase

            if (launch) begin
                case (nxt)
                    ARG: begin
                        state     <= ARG;
                        io_strobe <= 1'b1;
                        io_din    <= is_dma ? {7'b1111000, arg[4], 4'b0000, arg[3:0]} : arg;
                        nxt       <= is_dma ? PAD : END;
                    end
                    PAD: begin
                        state     <= PAD;
                        io_strobe <= 1'b1;
                        nxt       <= (cnt == 8'd0) ? END : DATA;
                    end
                    DATA: begin
                        if (!is_wr || wr_valid) begin
                            state     <= DATA;
                            io_strobe <= 1'b1;
                            io_din    <= is_wr ? wr_data : 16'h0000;
                            wr_ready  <= is_wr;
                            cnt       <= cnt - 8'd1;
                            nxt       <= (cnt == 8'd1) ? END : DATA;
                        end else begin
                            state <= WAIT_WR;
                        end
                    end
                    default: begin
                        state   <= END;
                        io_uio  <= 1'b0;
                        end_cnt <= END_LD;
                    end
                endcase
            end
        end
    end
endmodule
